viterbi_acs_traceback: RTL and testbench

Downstream consumer of the input buffer in the Viterbi decoder datapath. Takes one 16-bit block of eight received hard-decision bit pairs and runs Hamming branch metrics and add-compare-select over a 4-state trellis (K=3, generators 7/5 octal). It then traces back the survivors, emits 8 decoded bits, and pulses `refresh` so the buffer presents its next block.

---
 rtl/viterbi_acs_traceback.sv | 187 ++++++++++++++++++
 tb/tb_viterbi_acs_traceback.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_traceback.sv
// Hard-decision K=3 (7/5) Viterbi decoder for 8-pair blocks: 8 ACS steps, best-state select, 8-step traceback.
// Fixed 18-edge latency from start to data_valid/refresh; start is ignored until the FSM is back in IDLE.
module viterbi_acs_traceback #(
  parameter int PM_W    = 5,
  parameter int INIT_PM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] bit_pair_0,
  input  logic [1:0] bit_pair_1,
  input  logic [1:0] bit_pair_2,
  input  logic [1:0] bit_pair_3,
  input  logic [1:0] bit_pair_4,
  input  logic [1:0] bit_pair_5,
  input  logic [1:0] bit_pair_6,
  input  logic [1:0] bit_pair_7,
  output logic [7:0] decoded_data,
  output logic       data_valid,
  output logic       refresh,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACS,
    S_SELECT,
    S_TRACE,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [15:0]              rx_q, rx_d;
  logic [3:0][PM_W-1:0]     pm_q, pm_d;
  logic [7:0][3:0]          surv_q, surv_d;
  logic [2:0]               step_q, step_d;
  logic [1:0]               tst_q, tst_d;
  logic [7:0]               decoded_q, decoded_d;
  logic                     valid_q, valid_d;
  logic                     refresh_q, refresh_d;
  logic                     busy_q, busy_d;

  logic [1:0]               rx_pair;
  logic [1:0]               nsv;
  logic [1:0]               pred0;
  logic [1:0]               pred1;
  logic [PM_W-1:0]          cand0;
  logic [PM_W-1:0]          cand1;
  logic [3:0]               dec;
  logic [1:0]               idx;
  logic [1:0]               best;
  logic [PM_W-1:0]          best_pm;

  // Hamming distance between the received pair and the encoder output {c0,c1} for (pred, u).
  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic u,
                                               input logic [1:0] pred);
    logic [1:0] diff;
    diff = rx ^ {u ^ pred[1] ^ pred[0], u ^ pred[0]};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  always_comb begin
    state_d   = state_q;
    rx_d      = rx_q;
    pm_d      = pm_q;
    surv_d    = surv_q;
    step_d    = step_q;
    tst_d     = tst_q;
    decoded_d = decoded_q;
    valid_d   = 1'b0;
    refresh_d = 1'b0;
    rx_pair   = rx_q[{step_q, 1'b0} +: 2];
    nsv       = 2'd0;
    pred0     = 2'd0;
    pred1     = 2'd0;
    cand0     = '0;
    cand1     = '0;
    dec       = 4'd0;
    idx       = 2'd0;
    best      = 2'd0;
    best_pm   = pm_q[0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rx_d    = {bit_pair_7, bit_pair_6, bit_pair_5, bit_pair_4,
                     bit_pair_3, bit_pair_2, bit_pair_1, bit_pair_0};
          pm_d[0] = '0;
          pm_d[1] = PM_W'(INIT_PM);
          pm_d[2] = PM_W'(INIT_PM);
          pm_d[3] = PM_W'(INIT_PM);
          step_d  = 3'd0;
          state_d = S_ACS;
        end
      end

      S_ACS: begin
        for (int ns = 0; ns < 4; ns++) begin
          nsv   = 2'(ns);
          pred0 = {nsv[0], 1'b0};
          pred1 = {nsv[0], 1'b1};
          cand0 = pm_q[pred0] + PM_W'(branch_metric(rx_pair, nsv[1], pred0));
          cand1 = pm_q[pred1] + PM_W'(branch_metric(rx_pair, nsv[1], pred1));
          // Strict compare so equal candidates keep the even predecessor.
          if (cand1 < cand0) begin
            pm_d[nsv] = cand1;
            dec[nsv]  = 1'b1;
          end else begin
            pm_d[nsv] = cand0;
            dec[nsv]  = 1'b0;
          end
        end
        surv_d[step_q] = dec;
        step_d         = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = S_SELECT;
        end
      end

      S_SELECT: begin
        for (int i = 1; i < 4; i++) begin
          idx = 2'(i);
          if (pm_q[idx] < best_pm) begin
            best_pm = pm_q[idx];
            best    = idx;
          end
        end
        tst_d   = best;
        step_d  = 3'd7;
        state_d = S_TRACE;
      end

      S_TRACE: begin
        decoded_d[step_q] = tst_q[1];
        tst_d             = {tst_q[0], surv_q[step_q][tst_q]};
        step_d            = step_q - 3'd1;
        if (step_q == 3'd0) begin
          valid_d   = 1'b1;
          refresh_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_q      <= '0;
      pm_q      <= '0;
      surv_q    <= '0;
      step_q    <= '0;
      tst_q     <= '0;
      decoded_q <= '0;
      valid_q   <= 1'b0;
      refresh_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_d;
      pm_q      <= pm_d;
      surv_q    <= surv_d;
      step_q    <= step_d;
      tst_q     <= tst_d;
      decoded_q <= decoded_d;
      valid_q   <= valid_d;
      refresh_q <= refresh_d;
      busy_q    <= busy_d;
    end
  end

  assign decoded_data = decoded_q;
  assign data_valid   = valid_q;
  assign refresh      = refresh_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_viterbi_acs_traceback.sv
// Bench for viterbi_acs_traceback: directed scenarios plus random blocks against a path-history reference model.
module tb_viterbi_acs_traceback;

  localparam int INIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word;
  logic [7:0]  decoded_data;
  logic        data_valid;
  logic        refresh;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  viterbi_acs_traceback #(.PM_W(5), .INIT_PM(INIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bit_pair_0   (word[1:0]),
    .bit_pair_1   (word[3:2]),
    .bit_pair_2   (word[5:4]),
    .bit_pair_3   (word[7:6]),
    .bit_pair_4   (word[9:8]),
    .bit_pair_5   (word[11:10]),
    .bit_pair_6   (word[13:12]),
    .bit_pair_7   (word[15:14]),
    .decoded_data (decoded_data),
    .data_valid   (data_valid),
    .refresh      (refresh),
    .busy         (busy)
  );

  // Encoder: state s = {u[t-1],u[t-2]}, output pair {c0,c1}.
  function automatic int enc_pair(input int s, input int u);
    int c0, c1;
    c0 = u ^ ((s >> 1) & 1) ^ (s & 1);
    c1 = u ^ (s & 1);
    return c0 * 2 + c1;
  endfunction

  function automatic int enc_next(input int s, input int u);
    return u * 2 + ((s >> 1) & 1);
  endfunction

  function automatic logic [15:0] encode(input logic [7:0] msg);
    int s;
    int p;
    logic [15:0] w;
    s = 0;
    w = '0;
    for (int t = 0; t < 8; t++) begin
      p = enc_pair(s, int'(msg[t]));
      w[2*t +: 2] = 2'(p);
      s = enc_next(s, int'(msg[t]));
    end
    return w;
  endfunction

  // Reference decoder keeping whole surviving input histories per state.
  function automatic logic [7:0] model_decode(input logic [15:0] w);
    int pm[4];
    int npm[4];
    logic [7:0] path[4];
    logic [7:0] npath[4];
    int rx, ns, cand, best;
    pm = '{0, INIT, INIT, INIT};
    for (int s = 0; s < 4; s++) path[s] = '0;
    for (int t = 0; t < 8; t++) begin
      rx = int'(w[2*t +: 2]);
      for (int s = 0; s < 4; s++) begin
        npm[s]   = 1000;
        npath[s] = '0;
      end
      for (int pred = 0; pred < 4; pred++) begin
        for (int u = 0; u < 2; u++) begin
          ns   = enc_next(pred, u);
          cand = pm[pred] + $countones(2'(rx ^ enc_pair(pred, u)));
          if (cand < npm[ns]) begin
            npm[ns]      = cand;
            npath[ns]    = path[pred];
            npath[ns][t] = (u == 1);
          end
        end
      end
      pm   = npm;
      path = npath;
    end
    best = 0;
    for (int s = 1; s < 4; s++) if (pm[s] < pm[best]) best = s;
    return path[best];
  endfunction

  // Launch one decode and watch negedges after the accepting edge; lat = -1 if no pulse.
  task automatic run_decode(input logic [15:0] w, output int lat, output logic [7:0] d,
                            output logic rf);
    @(negedge clk);
    word  = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    d   = '0;
    rf  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (data_valid) begin
        lat = c;
        d   = decoded_data;
        rf  = refresh;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    word  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (decoded_data !== 8'h00 || data_valid !== 1'b0 || refresh !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got dd=%h dv=%b rf=%b busy=%b, want 00 0 0 0",
               decoded_data, data_valid, refresh, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_zero;
    int lat;
    logic [7:0] d;
    logic rf;
    run_decode(16'h0000, lat, d, rf);
    checks++;
    if (lat !== 18) begin
      errors++;
      $display("FAIL zero_latency: got %0d, want 18", lat);
    end
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL zero_data: got %h, want 00", d);
    end
    checks++;
    if (rf !== 1'b1) begin
      errors++;
      $display("FAIL zero_refresh: got %b, want 1", rf);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || refresh !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: got busy=%b dv=%b rf=%b, want 0 0 0", busy, data_valid, refresh);
    end
  endtask

  task automatic test_known_words;
    logic [15:0] words[2];
    int lat;
    logic [7:0] d;
    logic rf;
    words = '{16'h0D4B, 16'h0D5B};
    for (int i = 0; i < 2; i++) begin
      run_decode(words[i], lat, d, rf);
      checks++;
      if (lat !== 18 || d !== 8'h0D) begin
        errors++;
        $display("FAIL known_word_%h: got lat=%0d data=%h, want 18 0d", words[i], lat, d);
      end
      checks++;
      if (model_decode(words[i]) !== 8'h0D) begin
        errors++;
        $display("FAIL model_known_%h: got %h, want 0d", words[i], model_decode(words[i]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_input_change_restart;
    int pulses, first_c;
    logic [7:0] first_d;
    pulses  = 0;
    first_c = -1;
    first_d = '0;
    @(negedge clk);
    word  = 16'h0D4B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (data_valid) begin
        pulses++;
        if (first_c < 0) begin
          first_c = c;
          first_d = decoded_data;
        end
      end
      if (c == 2) word = 16'hFFFF;
      if (c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1 || first_c !== 18 || first_d !== 8'h0D) begin
      errors++;
      $display("FAIL restart_ignored: got pulses=%0d at=%0d data=%h, want 1 18 0d",
               pulses, first_c, first_d);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_no_second: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] w;
    int pulses, lat;
    logic [7:0] d;
    logic rf;
    w      = encode(8'hA5);
    pulses = 0;
    @(negedge clk);
    word  = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (data_valid || refresh) pulses++;
      if (c == 11) rst = 1'b1;
      if (c == 12) begin
        checks++;
        if (busy !== 1'b0 || decoded_data !== 8'h00 || data_valid !== 1'b0) begin
          errors++;
          $display("FAIL midreset_state: got busy=%b dd=%h dv=%b, want 0 00 0",
                   busy, decoded_data, data_valid);
        end
        rst = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midreset_pulses: got %0d, want 0", pulses);
    end
    run_decode(w, lat, d, rf);
    checks++;
    if (lat !== 18 || d !== 8'hA5) begin
      errors++;
      $display("FAIL midreset_redecode: got lat=%0d data=%h, want 18 a5", lat, d);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int at[$];
    logic [7:0] dd[$];
    int want[3];
    want = '{18, 37, 56};
    @(negedge clk);
    word  = 16'h0D4B;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 60; c++) begin
      if (data_valid) begin
        at.push_back(c);
        dd.push_back(decoded_data);
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (at.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, want 3", at.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (at[i] !== want[i] || dd[i] !== 8'h0D) begin
          errors++;
          $display("FAIL b2b_pulse%0d: got at=%0d data=%h, want %0d 0d", i, at[i], dd[i], want[i]);
        end
      end
    end
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_random;
    logic [7:0] msg;
    logic [15:0] w;
    int lat;
    logic [7:0] d;
    logic rf;
    for (int i = 0; i < 40; i++) begin
      msg = 8'($urandom);
      if (i % 4 == 0) w = encode(msg);
      else if (i % 4 == 1) w = encode(msg) ^ (16'h1 << $urandom_range(15, 0));
      else w = 16'($urandom);
      run_decode(w, lat, d, rf);
      checks++;
      if (lat !== 18 || rf !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_timing: got lat=%0d rf=%b, want 18 1", i, lat, rf);
      end
      checks++;
      if (d !== model_decode(w)) begin
        errors++;
        $display("FAIL rand%0d_data word=%h: got %h, want %h", i, w, d, model_decode(w));
      end
      if (i % 4 == 0) begin
        checks++;
        if (d !== msg) begin
          errors++;
          $display("FAIL rand%0d_clean word=%h: got %h, want %h", i, w, d, msg);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    word  = '0;
    test_reset;
    test_all_zero;
    test_known_words;
    test_input_change_restart;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
